// File: rtl/wb_ram_arbiter2.sv
// Two-master / one-slave Wishbone arbiter in front of the on-chip RAM.
// Round-robin grant on contention, the bus is held for the owner's whole
// cycle, and a per-transfer watchdog forces an error if the slave never answers.
module wb_ram_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // master 0 (instruction)
    input  logic [DW-1:0]   m0_data_i,
    output logic [DW-1:0]   m0_data_o,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    // master 1 (data)
    input  logic [DW-1:0]   m1_data_i,
    output logic [DW-1:0]   m1_data_o,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    // slave (RAM)
    output logic [DW-1:0]   s_data_o,
    input  logic [DW-1:0]   s_data_i,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    // current owner, one-hot
    output logic [1:0]      gnt_o
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic       last, last_nxt;     // master that owned the bus most recently
    logic [7:0] wdog, wdog_nxt;

    logic own0, own1;               // grant as seen by the outputs (forced off during reset)
    logic cur_cyc, cur_stb;         // owner's cyc/stb, ungated
    logic slv_resp;
    logic wd_fire;

    assign own0     = (state == OWN0) && !rst_i;
    assign own1     = (state == OWN1) && !rst_i;
    assign cur_cyc  = (state == OWN0) ? m0_cyc_i : (state == OWN1) ? m1_cyc_i : 1'b0;
    assign cur_stb  = (state == OWN0) ? m0_stb_i : (state == OWN1) ? m1_stb_i : 1'b0;
    assign slv_resp = s_ack_i | s_err_i | s_rty_i;

    // A slave ack in the same cycle as the timeout wins over the forced error.
    assign wd_fire  = (own0 | own1) && cur_stb && (wdog == TIMEOUT_C) && !s_ack_i;

    // Read data is broadcast; only ack/err/rty are steered to the owner.
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign gnt_o     = {own1, own0};

    // Slave-side mux and owner-only response routing.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch can be inferred.
        s_data_o = '0;
        s_addr_o = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        if (own0) begin
            s_data_o = m0_data_i;
            s_addr_o = m0_addr_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
        end else if (own1) begin
            s_data_o = m1_data_i;
            s_addr_o = m1_addr_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
        end
        s_cyc_o  = (own0 | own1) & cur_cyc;
        s_stb_o  = (own0 | own1) & cur_stb & ~wd_fire;
        m0_ack_o = own0 & s_ack_i;
        m0_err_o = own0 & (s_err_i | wd_fire);
        m0_rty_o = own0 & s_rty_i;
        m1_ack_o = own1 & s_ack_i;
        m1_err_o = own1 & (s_err_i | wd_fire);
        m1_rty_o = own1 & s_rty_i;
    end

    // Arbitration, release hand-over and watchdog counting.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        wdog_nxt  = wdog;
        case (state)
            IDLE: begin
                wdog_nxt = '0;
                if (m0_cyc_i && m1_cyc_i) state_nxt = last ? OWN0 : OWN1;
                else if (m0_cyc_i)        state_nxt = OWN0;
                else if (m1_cyc_i)        state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                if (!cur_cyc) begin
                    // Release: hand straight to a waiting master, no idle cycle.
                    last_nxt = (state == OWN1);
                    wdog_nxt = '0;
                    if (state == OWN0) state_nxt = m1_cyc_i ? OWN1 : IDLE;
                    else               state_nxt = m0_cyc_i ? OWN0 : IDLE;
                end else if (slv_resp || wd_fire) begin
                    wdog_nxt = '0;
                end else if (s_stb_o) begin
                    wdog_nxt = wdog + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: registers use non-blocking assignments so all of them update from the same pre-edge values.
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            wdog  <= wdog_nxt;
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter2.sv
// Directed bench for wb_ram_arbiter2 with a small registered-ack RAM stub.
module tb_wb_ram_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [DW-1:0] RDATA = 32'h1234_5678;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [DW-1:0] m0_data_i, m0_data_o, m1_data_i, m1_data_o;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i;
    logic m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o, m0_rty_o;
    logic m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o, m1_rty_o;
    logic [DW-1:0] s_data_o, s_data_i;
    logic [AW-1:0] s_addr_o;
    logic [DW/8-1:0] s_sel_o;
    logic s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
    logic [1:0] gnt_o;

    logic ack_q, ack_en, ack_force;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk_i = ~clk_i;

    // RAM stub: acks one cycle after a strobe, never twice in a row.
    always_ff @(posedge clk_i) ack_q <= ack_en & s_cyc_o & s_stb_o & ~ack_q;
    assign s_ack_i  = ack_q | ack_force;
    assign s_err_i  = 1'b0;
    assign s_rty_i  = 1'b0;
    assign s_data_i = RDATA;

    wb_ram_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_addr_i(m0_addr_i), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_addr_i(m1_addr_i), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_data_o(s_data_o), .s_data_i(s_data_i), .s_addr_o(s_addr_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else pass_cnt++;
    endtask

    // Hard stop in case something stalls beyond all bounded loops.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int   acks;
        int   nacks;
        logic exp_own;

        rst_i = 1'b1;
        m0_data_i = '0; m0_addr_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
        m1_data_i = '0; m1_addr_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        ack_en = 1'b1; ack_force = 1'b0;
        // a request held during reset must not be granted
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_s_cyc", s_cyc_o, 1'b0);
        check("rst_s_stb", s_stb_o, 1'b0);
        check("rst_data_bcast", m0_data_o, RDATA);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_gnt", gnt_o, 2'b00);

        // m1 single write
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
        m1_addr_i = 32'h100; m1_data_i = 32'hDEAD_BEEF; m1_sel_i = 4'hF;
        #1;
        check("wr_grant_latency", s_cyc_o, 1'b0);
        @(negedge clk_i);
        check("wr_gnt", gnt_o, 2'b10);
        check("wr_s_addr", s_addr_o, 32'h100);
        check("wr_s_data", s_data_o, 32'hDEAD_BEEF);
        check("wr_s_we", s_we_o, 1'b1);
        check("wr_s_sel", s_sel_o, 4'hF);
        check("wr_s_cyc", s_cyc_o, 1'b1);
        check("wr_s_stb", s_stb_o, 1'b1);
        @(negedge clk_i);
        check("wr_m1_ack", m1_ack_o, 1'b1);
        check("wr_m0_ack", m0_ack_o, 1'b0);
        check("wr_m1_data", m1_data_o, RDATA);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        @(negedge clk_i);
        check("wr_release_gnt", gnt_o, 2'b00);

        // simultaneous request right after reset: m0 first, then m1 with no gap
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        m0_addr_i = 32'h200; m1_addr_i = 32'h204;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        @(negedge clk_i);
        check("tie_gnt_m0", gnt_o, 2'b01);
        check("tie_s_addr", s_addr_o, 32'h200);
        @(negedge clk_i);
        check("tie_m0_ack", m0_ack_o, 1'b1);
        check("tie_m1_ack_blocked", m1_ack_o, 1'b0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk_i);
        check("tie_handover_gnt", gnt_o, 2'b10);
        check("tie_handover_addr", s_addr_o, 32'h204);
        @(negedge clk_i);
        check("tie_m1_ack", m1_ack_o, 1'b1);
        check("tie_m0_ack_blocked", m0_ack_o, 1'b0);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        @(negedge clk_i);

        // bus hold: m0 does 4 beats while m1 waits
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        @(negedge clk_i);
        check("hold_first_gnt", gnt_o, 2'b01);
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        acks = 0;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            @(negedge clk_i);
            check("hold_gnt", gnt_o, 2'b01);
            check("hold_m1_ack", m1_ack_o, 1'b0);
            if (m0_ack_o) acks++;
        end
        check("hold_acks", acks, 4);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk_i);
        check("hold_release_gnt", gnt_o, 2'b10);
        @(negedge clk_i);
        check("hold_m1_ack_after", m1_ack_o, 1'b1);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        @(negedge clk_i);

        // watchdog: RAM never acks, TIMEOUT = 8
        ack_en = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk_i);
            check("wd_gnt", gnt_o, 2'b01);
            check("wd_m0_err", m0_err_o, c == 8);
            check("wd_s_stb", s_stb_o, c != 8);
            check("wd_m1_err", m1_err_o, 1'b0);
            if (c == 0) begin
                m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
            end
        end
        // ack arriving exactly at the timeout suppresses the error and restarts the count
        for (int c = 10; c <= 26; c++) begin
            @(negedge clk_i);
            if (c == 17) begin
                ack_force = 1'b1;
                #1;
                check("wd_ack_wins_ack", m0_ack_o, 1'b1);
                check("wd_ack_wins_err", m0_err_o, 1'b0);
            end else begin
                ack_force = 1'b0;
                #1;
                check("wd2_m0_err", m0_err_o, c == 26);
                check("wd2_m1_err", m1_err_o, 1'b0);
            end
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk_i);
        check("wd_handover_gnt", gnt_o, 2'b10);
        check("wd_m1_err_after", m1_err_o, 1'b0);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        ack_en = 1'b1;
        @(negedge clk_i);

        // reset during an m1 read with an ack in flight
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h300;
        @(negedge clk_i);
        check("rstmid_gnt_before", gnt_o, 2'b10);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rstmid_gnt", gnt_o, 2'b00);
        check("rstmid_s_cyc", s_cyc_o, 1'b0);
        check("rstmid_s_stb", s_stb_o, 1'b0);
        check("rstmid_m1_ack", m1_ack_o, 1'b0);
        rst_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        @(negedge clk_i);

        // continuous single-beat round-robin
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        exp_own = 1'b0;
        nacks = 0;
        for (int c = 0; c < 40 && nacks < 6; c++) begin
            @(negedge clk_i);
            check("rr_no_idle", gnt_o == 2'b00, 1'b0);
            if (m0_ack_o || m1_ack_o) begin
                check("rr_ack_owner", {m1_ack_o, m0_ack_o}, exp_own ? 2'b10 : 2'b01);
                check("rr_gnt", gnt_o, exp_own ? 2'b10 : 2'b01);
                exp_own = ~exp_own;
                nacks++;
            end
            if (m0_ack_o) begin
                m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
            end else if (!m0_cyc_i) begin
                m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
            end
            if (m1_ack_o) begin
                m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
            end else if (!m1_cyc_i) begin
                m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
            end
        end
        check("rr_acks", nacks, 6);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("end_idle_gnt", gnt_o, 2'b00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
